// File: rtl/micro_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// micro_sequencer_pkg
// Shared constants for the microprogram sequencer slice:
//   - sequencing opcodes carried in the top three bits of every microword
//   - FSM state encodings
//   - helper functions that locate each microword field from the
//     microaddress width and the control-bit count
// Microword layout, MSB first: seq_op[2:0], cond_sel[2:0],
// target[UADDR_W-1:0], ctrl[CTRL_W-1:0].
// ---------------------------------------------------------------------------
package micro_sequencer_pkg;

    localparam int SEQ_OP_W = 3;
    localparam int COND_W   = 3;

    localparam logic [2:0] SEQ_INC   = 3'd0;
    localparam logic [2:0] SEQ_JMP   = 3'd1;
    localparam logic [2:0] SEQ_BR    = 3'd2;
    localparam logic [2:0] SEQ_MAP   = 3'd3;
    localparam logic [2:0] SEQ_CALL  = 3'd4;
    localparam logic [2:0] SEQ_RET   = 3'd5;
    localparam logic [2:0] SEQ_FETCH = 3'd6;
    localparam logic [2:0] SEQ_HALT  = 3'd7;

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_WAIT_STEP = 2'd1;
    localparam logic [1:0] ST_HALT      = 2'd2;

    function automatic int target_lsb(input int ctrl_w);
        return ctrl_w;
    endfunction

    function automatic int cond_lsb(input int uaddr_w, input int ctrl_w);
        return ctrl_w + uaddr_w;
    endfunction

    function automatic int seq_op_lsb(input int uaddr_w, input int ctrl_w);
        return ctrl_w + uaddr_w + COND_W;
    endfunction

    function automatic int cm_word_w(input int uaddr_w, input int ctrl_w);
        return ctrl_w + uaddr_w + COND_W + SEQ_OP_W;
    endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// ---------------------------------------------------------------------------
// micro_sequencer_if
// Control-memory bus between the sequencer and an external combinational
// control store.
//   car     : microaddress presented by the sequencer
//   cm_data : microword read back combinationally at car
// Modports: master = sequencer side, slave = control-memory side.
// ---------------------------------------------------------------------------
import micro_sequencer_pkg::*;

interface micro_sequencer_if #(
    parameter int UADDR_W = 7,
    parameter int CTRL_W  = 21
);
    logic [UADDR_W-1:0]                     car;
    logic [cm_word_w(UADDR_W, CTRL_W)-1:0]  cm_data;

    modport master (output car, input  cm_data);
    modport slave  (input  car, output cm_data);
endinterface

// File: rtl/micro_stack.sv
// ---------------------------------------------------------------------------
// micro_stack
// Small LIFO holding micro-call return addresses.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset (clears pointer only)
//   i_push, i_data : push i_data (ignored when full)
//   i_pop          : drop top entry (ignored when empty)
//   o_full/o_empty : pointer at DEPTH / at 0
//   o_data         : current top entry (valid when not empty)
// ---------------------------------------------------------------------------
module micro_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 7
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_data
);
    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] r_sp;
    logic [WIDTH-1:0] r_mem [0:(1 << IDX_W) - 1];
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;

    assign o_full   = (r_sp == PTR_W'(DEPTH));
    assign o_empty  = (r_sp == '0);
    assign w_wr_idx = r_sp[IDX_W-1:0];
    // When the pointer equals a power-of-two DEPTH its low bits are zero,
    // so the decrement wraps to DEPTH-1, which is the correct top slot.
    assign w_rd_idx = r_sp[IDX_W-1:0] - IDX_W'(1);
    assign o_data   = r_mem[w_rd_idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sp <= '0;
        end else if (i_push && !o_full) begin
            r_sp <= r_sp + PTR_W'(1);
        end else if (i_pop && !o_empty) begin
            r_sp <= r_sp - PTR_W'(1);
        end
    end

    // Contents are deliberately not reset; only the pointer matters.
    always_ff @(posedge i_clk) begin
        if (i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// ---------------------------------------------------------------------------
// micro_sequencer
// Microprogram sequencer: owns the control address register (CAR), the
// micro-call stack and the control buffer register (CBR).
// Ports:
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_step_mode             : pause at each FETCH (instruction boundary)
//   i_next_instr_stimulus   : step request, rising-edge detected
//   i_opcode, i_flags       : dispatch opcode and branch flags
//   cm_bus (master)         : CAR out, microword in
//   o_car                   : current microaddress
//   o_ctrl, o_ctrl_valid    : registered control bits and their valid
//   o_IF_stage              : CBR word came from the fetch routine
//   o_halt, o_stack_err     : halted, and whether a stack fault caused it
// ---------------------------------------------------------------------------
import micro_sequencer_pkg::*;

module micro_sequencer #(
    parameter int UADDR_W     = 7,
    parameter int CTRL_W      = 21,
    parameter int OPC_W       = 5,
    parameter int FLAG_W      = 5,
    parameter int STACK_DEPTH = 4,
    parameter int MAP_BASE    = 32,
    parameter int FETCH_LEN   = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_step_mode,
    input  logic               i_next_instr_stimulus,
    input  logic [OPC_W-1:0]   i_opcode,
    input  logic [FLAG_W-1:0]  i_flags,
    micro_sequencer_if.master  cm_bus,
    output logic [UADDR_W-1:0] o_car,
    output logic [CTRL_W-1:0]  o_ctrl,
    output logic               o_ctrl_valid,
    output logic               o_IF_stage,
    output logic               o_halt,
    output logic               o_stack_err
);
    localparam int TGT_LSB  = target_lsb(CTRL_W);
    localparam int COND_LSB = cond_lsb(UADDR_W, CTRL_W);
    localparam int OP_LSB   = seq_op_lsb(UADDR_W, CTRL_W);

    logic [1:0]         r_state;
    logic [UADDR_W-1:0] r_car;
    logic [CTRL_W-1:0]  r_ctrl;
    logic               r_ctrl_valid;
    logic               r_if_stage;
    logic               r_halt;
    logic               r_stack_err;
    logic               r_stim_prev;

    logic [2:0]         w_seq_op;
    logic [2:0]         w_cond_sel;
    logic [UADDR_W-1:0] w_target;
    logic [CTRL_W-1:0]  w_ctrl;
    logic [UADDR_W-1:0] w_car_inc;
    logic [UADDR_W-1:0] w_map_addr;
    logic [UADDR_W-1:0] w_next_car;
    logic [UADDR_W-1:0] w_stack_top;
    logic               w_br_taken;
    logic               w_push;
    logic               w_pop;
    logic               w_err;
    logic               w_halt_op;
    logic               w_enter_wait;
    logic               w_full;
    logic               w_empty;
    logic               w_run;

    assign w_seq_op   = cm_bus.cm_data[OP_LSB +: 3];
    assign w_cond_sel = cm_bus.cm_data[COND_LSB +: 3];
    assign w_target   = cm_bus.cm_data[TGT_LSB +: UADDR_W];
    assign w_ctrl     = cm_bus.cm_data[0 +: CTRL_W];
    assign w_car_inc  = r_car + UADDR_W'(1);
    // Truncating cast gives the modulo-2^UADDR_W wrap of the dispatch sum.
    assign w_map_addr = UADDR_W'(MAP_BASE + int'(i_opcode));
    assign w_run      = (r_state == ST_RUN);

    // Selectors beyond the flag vector mean "branch always".
    always_comb begin
        w_br_taken = 1'b1;
        for (int k = 0; k < FLAG_W; k++) begin
            if (int'(w_cond_sel) == k) begin
                w_br_taken = i_flags[k];
            end
        end
    end

    always_comb begin
        w_next_car   = w_car_inc;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_err        = 1'b0;
        w_halt_op    = 1'b0;
        w_enter_wait = 1'b0;
        case (w_seq_op)
            SEQ_JMP:   w_next_car = w_target;
            SEQ_BR:    if (w_br_taken) w_next_car = w_target;
            SEQ_MAP:   w_next_car = w_map_addr;
            SEQ_CALL: begin
                if (w_full) begin
                    w_err = 1'b1;
                end else begin
                    w_push     = 1'b1;
                    w_next_car = w_target;
                end
            end
            SEQ_RET: begin
                if (w_empty) begin
                    w_err = 1'b1;
                end else begin
                    w_pop      = 1'b1;
                    w_next_car = w_stack_top;
                end
            end
            SEQ_FETCH: begin
                w_next_car   = '0;
                w_enter_wait = i_step_mode;
            end
            SEQ_HALT:  w_halt_op = 1'b1;
            default:   w_next_car = w_car_inc;
        endcase
    end

    micro_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (UADDR_W)
    ) u_stack (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push && w_run),
        .i_pop   (w_pop && w_run),
        .i_data  (w_car_inc),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_data  (w_stack_top)
    );

    // Halting and wait-entry words never reach the CBR: the outputs read
    // as idle from the very edge that changes state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_RUN;
            r_car        <= '0;
            r_ctrl       <= '0;
            r_ctrl_valid <= 1'b0;
            r_if_stage   <= 1'b0;
            r_halt       <= 1'b0;
            r_stack_err  <= 1'b0;
            r_stim_prev  <= 1'b0;
        end else begin
            r_stim_prev <= i_next_instr_stimulus;
            case (r_state)
                ST_RUN: begin
                    if (w_halt_op || w_err) begin
                        r_state      <= ST_HALT;
                        r_ctrl       <= '0;
                        r_ctrl_valid <= 1'b0;
                        r_if_stage   <= 1'b0;
                        r_halt       <= 1'b1;
                        r_stack_err  <= w_err;
                    end else if (w_enter_wait) begin
                        r_state      <= ST_WAIT_STEP;
                        r_car        <= '0;
                        r_ctrl       <= '0;
                        r_ctrl_valid <= 1'b0;
                        r_if_stage   <= 1'b0;
                    end else begin
                        r_car        <= w_next_car;
                        r_ctrl       <= w_ctrl;
                        r_ctrl_valid <= 1'b1;
                        r_if_stage   <= (int'(r_car) < FETCH_LEN);
                    end
                end
                ST_WAIT_STEP: begin
                    if (!i_step_mode || (i_next_instr_stimulus && !r_stim_prev)) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign cm_bus.car   = r_car;
    assign o_car        = r_car;
    assign o_ctrl       = r_ctrl;
    assign o_ctrl_valid = r_ctrl_valid;
    assign o_IF_stage   = r_if_stage;
    assign o_halt       = r_halt;
    assign o_stack_err  = r_stack_err;

endmodule

// File: tb/tb_micro_sequencer.sv
// ---------------------------------------------------------------------------
// tb_micro_sequencer
// Drives the sequencer from a behavioural control-memory array and compares
// every cycle against a queue-based reference model, plus directed scenarios.
// A second instance with MAP_BASE=100 exercises dispatch wrap-around.
// ---------------------------------------------------------------------------
module tb_micro_sequencer;

    localparam int UW = 7;
    localparam int CW = 21;
    localparam int WW = CW + UW + 6;
    localparam int DEPTH = 4;
    localparam int FL = 3;
    localparam int MB = 32;

    localparam bit [2:0] OP_INC = 3'd0, OP_JMP = 3'd1, OP_BR = 3'd2, OP_MAP = 3'd3;
    localparam bit [2:0] OP_CALL = 3'd4, OP_RET = 3'd5, OP_FETCH = 3'd6, OP_HALT = 3'd7;

    logic          clk = 1'b0;
    logic          rstN;
    logic          stepMode;
    logic          stim;
    logic [4:0]    opcode;
    logic [4:0]    flags;
    logic [UW-1:0] car, car2;
    logic [CW-1:0] ctrl, ctrl2;
    logic          valid, valid2, ifStage, ifStage2, halt, halt2, stackErr, stackErr2;

    logic [WW-1:0] mem [128];

    always #5 clk = ~clk;

    micro_sequencer_if #(.UADDR_W(UW), .CTRL_W(CW)) cmBus ();
    micro_sequencer_if #(.UADDR_W(UW), .CTRL_W(CW)) cmBus2 ();

    assign cmBus.cm_data  = mem[cmBus.car];
    assign cmBus2.cm_data = (cmBus2.car == 7'd0) ? {3'd3, 3'd0, 7'd0, 21'h0ABCDE}
                                                 : {3'd7, 3'd0, 7'd0, 21'h1FFFFF};

    micro_sequencer dut (
        .i_clk(clk), .i_rst_n(rstN), .i_step_mode(stepMode),
        .i_next_instr_stimulus(stim), .i_opcode(opcode), .i_flags(flags),
        .cm_bus(cmBus), .o_car(car), .o_ctrl(ctrl), .o_ctrl_valid(valid),
        .o_IF_stage(ifStage), .o_halt(halt), .o_stack_err(stackErr)
    );

    micro_sequencer #(.MAP_BASE(100)) dut2 (
        .i_clk(clk), .i_rst_n(rstN), .i_step_mode(stepMode),
        .i_next_instr_stimulus(stim), .i_opcode(opcode), .i_flags(flags),
        .cm_bus(cmBus2), .o_car(car2), .o_ctrl(ctrl2), .o_ctrl_valid(valid2),
        .o_IF_stage(ifStage2), .o_halt(halt2), .o_stack_err(stackErr2)
    );

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference model: sequencer behaviour written from the rules directly.
    typedef enum {M_RUN, M_WAIT, M_HALT} modelMode_t;
    modelMode_t    mMode;
    int            mCar;
    int            mStack[$];
    logic [CW-1:0] mCtrl;
    bit            mValid, mIf, mHalt, mErr, mPrevStim;

    task automatic modelReset();
        mMode = M_RUN; mCar = 0; mStack.delete(); mCtrl = '0;
        mValid = 0; mIf = 0; mHalt = 0; mErr = 0; mPrevStim = 0;
    endtask

    task automatic modelEdge();
        logic [WW-1:0] w;
        int op, cs, tgt, nxt;
        bit stop, fault, toWait;
        w = mem[mCar];
        op = int'(w[WW-1 -: 3]); cs = int'(w[WW-4 -: 3]); tgt = int'(w[CW +: UW]);
        stop = 0; fault = 0; toWait = 0;
        nxt = (mCar + 1) % 128;
        if (mMode == M_RUN) begin
            case (op)
                1: nxt = tgt;
                2: if (cs >= 5 || flags[cs]) nxt = tgt;
                3: nxt = (MB + int'(opcode)) % 128;
                4: if (mStack.size() == DEPTH) fault = 1;
                   else begin mStack.push_back((mCar + 1) % 128); nxt = tgt; end
                5: if (mStack.size() == 0) fault = 1; else nxt = mStack.pop_back();
                6: begin nxt = 0; toWait = stepMode; end
                7: stop = 1;
                default: ;
            endcase
            if (stop || fault) begin
                mMode = M_HALT; mHalt = 1; mErr = fault; mCtrl = '0; mValid = 0; mIf = 0;
            end else if (toWait) begin
                mMode = M_WAIT; mCar = 0; mCtrl = '0; mValid = 0; mIf = 0;
            end else begin
                mIf = (mCar < FL); mCtrl = w[CW-1:0]; mValid = 1; mCar = nxt;
            end
        end else if (mMode == M_WAIT) begin
            if (!stepMode || (stim && !mPrevStim)) mMode = M_RUN;
        end
        mPrevStim = stim;
    endtask

    task automatic compareModel();
        checkOutput("car", car, mCar);
        checkOutput("ctrl", ctrl, mCtrl);
        checkOutput("ctrl_valid", valid, mValid);
        checkOutput("IF_stage", ifStage, mIf);
        checkOutput("halt", halt, mHalt);
        checkOutput("stack_err", stackErr, mErr);
    endtask

    task automatic applyStimulus(input bit sm, input bit st, input logic [4:0] opc, input logic [4:0] fl);
        stepMode = sm; stim = st; opcode = opc; flags = fl;
        modelEdge();
        @(posedge clk);
        #1;
        compareModel();
    endtask

    task automatic runFor(input int n, input logic [4:0] opc, input logic [4:0] fl);
        repeat (n) applyStimulus(1'b0, 1'b0, opc, fl);
    endtask

    // Called just after an edge, so the reset pulse sits between edges.
    task automatic applyReset();
        #1;
        rstN = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_car", car, 0);
        checkOutput("rst_halt", halt, 0);
        compareModel();
        #2;
        rstN = 1'b1;
    endtask

    function automatic logic [WW-1:0] mkWord(input bit [2:0] op, input bit [2:0] cs, input int tgt);
        return {op, cs, 7'(tgt), 21'($urandom)};
    endfunction

    task automatic loadProgram();
        for (int i = 0; i < 128; i++) mem[i] = mkWord(OP_FETCH, 3'd0, 0);
        mem[0]   = mkWord(OP_INC, 3'd0, 0);
        mem[1]   = mkWord(OP_INC, 3'd0, 0);
        mem[2]   = mkWord(OP_MAP, 3'd0, 0);
        mem[33]  = mkWord(OP_JMP, 3'd0, 10);
        mem[10]  = mkWord(OP_BR, 3'd0, 20);
        mem[34]  = mkWord(OP_JMP, 3'd0, 12);
        mem[12]  = mkWord(OP_CALL, 3'd0, 40);
        mem[40]  = mkWord(OP_RET, 3'd0, 0);
        mem[35]  = mkWord(OP_JMP, 3'd0, 14);
        mem[14]  = mkWord(OP_BR, 3'd7, 20);
        mem[36]  = mkWord(OP_CALL, 3'd0, 60);
        for (int i = 60; i < 64; i++) mem[i] = mkWord(OP_CALL, 3'd0, i + 1);
        mem[38]  = mkWord(OP_JMP, 3'd0, 50);
        mem[50]  = mkWord(OP_HALT, 3'd0, 0);
        mem[39]  = mkWord(OP_JMP, 3'd0, 127);
        mem[127] = mkWord(OP_INC, 3'd0, 0);
    endtask

    initial begin
        int cnt;
        rstN = 1'b0; stepMode = 0; stim = 0; opcode = 5'd31; flags = '0;
        loadProgram();
        repeat (2) @(posedge clk);
        applyReset();

        // Fetch routine then dispatch; second instance wraps 100+31 to 3.
        applyStimulus(0, 0, 5'd31, 0);
        checkOutput("t1_car1", car, 1);
        checkOutput("t1_if1", ifStage, 1);
        checkOutput("map_wrap_car", car2, 3);
        applyStimulus(0, 0, 5'd5, 0);
        checkOutput("t1_car2", car, 2);
        checkOutput("t1_ctrl1", ctrl, mem[1][CW-1:0]);
        checkOutput("halt2_after_map", halt2, 1);
        applyStimulus(0, 0, 5'd5, 0);
        checkOutput("t1_car37", car, 37);
        checkOutput("t1_if3", ifStage, 1);
        applyStimulus(0, 0, 5'd5, 0);
        checkOutput("t1_car0", car, 0);
        checkOutput("t1_if_off", ifStage, 0);
        checkOutput("t1_ctrl37", ctrl, mem[37][CW-1:0]);

        // Conditional branch.
        applyReset(); runFor(5, 5'd1, 5'b00001);
        checkOutput("br_taken", car, 20);
        applyReset(); runFor(5, 5'd1, 5'b00000);
        checkOutput("br_not_taken", car, 11);
        applyReset(); runFor(5, 5'd3, 5'($urandom));
        checkOutput("br_always", car, 20);

        // Call / return and stack overflow.
        applyReset(); runFor(4, 5'd2, 0);
        checkOutput("call_from", car, 12);
        runFor(1, 5'd2, 0);
        checkOutput("call_target", car, 40);
        runFor(1, 5'd2, 0);
        checkOutput("ret_addr", car, 13);
        applyReset(); runFor(7, 5'd4, 0);
        checkOutput("nest_no_halt", halt, 0);
        runFor(1, 5'd4, 0);
        checkOutput("ovf_halt", halt, 1);
        checkOutput("ovf_err", stackErr, 1);
        checkOutput("ovf_ctrl", ctrl, 0);

        // Single-step gating.
        applyReset();
        repeat (4) applyStimulus(1, 0, 5'd5, 0);
        cnt = 0;
        repeat (10) begin
            applyStimulus(1, 0, 5'd5, 0);
            if (car == 0 && valid == 0) cnt++;
        end
        checkOutput("wait_idle_cycles", cnt, 10);
        applyStimulus(1, 1, 5'd5, 0);
        applyStimulus(1, 0, 5'd5, 0);
        checkOutput("step_word0_ctrl", ctrl, mem[0][CW-1:0]);
        cnt = 1;
        repeat (10) begin
            applyStimulus(1, 0, 5'd5, 0);
            if (valid) cnt++;
        end
        checkOutput("pulse_words", cnt, 3);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, (i < 5), 5'd5, 0);
            if (valid) cnt++;
        end
        checkOutput("held_words", cnt, 3);
        applyStimulus(0, 0, 5'd5, 0);
        applyStimulus(0, 0, 5'd5, 0);
        checkOutput("step_drop_car", car, 1);

        // HALT word and asynchronous reset release.
        applyReset(); runFor(5, 5'd6, 0);
        checkOutput("halt_set", halt, 1);
        cnt = 0;
        repeat (20) begin
            runFor(1, 5'($urandom), 5'($urandom));
            if (car == 50 && halt) cnt++;
        end
        checkOutput("halt_frozen", cnt, 20);
        applyReset();

        // Address wrap on INC.
        runFor(5, 5'd7, 0);
        checkOutput("inc_wrap_car", car, 0);
        checkOutput("inc_wrap_ctrl", ctrl, mem[127][CW-1:0]);

        // Random microprograms and inputs.
        for (int ep = 0; ep < 20; ep++) begin
            for (int i = 0; i < 128; i++)
                mem[i] = mkWord(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), int'($urandom_range(0, 127)));
            applyReset();
            repeat (50) applyStimulus(($urandom % 4) == 0, 1'($urandom), 5'($urandom), 5'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
